// File: rtl/led_share_sched_if.sv
// Requester-side bundle for led_share_sched: request/colour/blink in, grant/busy out.
interface led_share_sched_if #(
  parameter int unsigned NREQ = 4
) ();
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] colour;
  logic [NREQ-1:0]   blink;
  logic [NREQ-1:0]   grant;
  logic              busy;

  modport master (output req, colour, blink, input grant, busy);
  modport slave  (input req, colour, blink, output grant, busy);
endinterface

// File: rtl/led_share_sched.sv
// Round-robin time-slicing of one RGB LED among NREQ requesters with dark gaps.
// Optional LED_ACTIVE_LOW_EN: drive the LED pins active-low (common-anode LED).
module led_share_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned TICK_DIV = 20000,
  parameter int unsigned SLOT_MS  = 500,
  parameter int unsigned BLINK_MS = 250,
  parameter int unsigned GAP_MS   = 100
) (
  input  logic              clk,
  input  logic              rst,
  led_share_sched_if.slave  bus,
  output logic              redled,
  output logic              greenled,
  output logic              blueled
);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif

  localparam int unsigned PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MS_MAX = (SLOT_MS > GAP_MS) ? SLOT_MS : GAP_MS;
  localparam int unsigned MW     = $clog2(MS_MAX + 1);
  localparam int unsigned BW     = $clog2(BLINK_MS + 1);
  localparam int unsigned OW     = $clog2(NREQ);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0] SLOT_LAST  = MW'(SLOT_MS - 1);
  localparam logic [MW-1:0] GAP_LAST   = MW'((GAP_MS > 0) ? GAP_MS - 1 : 0);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [MW-1:0]   ms_cnt_q, ms_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_owner_q, last_owner_d;
  logic [2:0]      col_q, col_d;
  logic            blink_en_q, blink_en_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [2:0]      led_q, led_d;

  logic            tick;
  logic [OW-1:0]   arb_base;
  logic [OW-1:0]   cand;
  logic            pick_vld;
  logic [OW-1:0]   pick_idx;
  logic [2:0]      sel_col;
  logic            sel_blink;
  logic            owner_req;
  logic            launch, to_gap, to_idle;
  logic [2:0]      lit;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    ms_cnt_d     = ms_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    col_d        = col_q;
    blink_en_d   = blink_en_q;
    launch       = 1'b0;
    to_gap       = 1'b0;
    to_idle      = 1'b0;
    cand         = '0;
    pick_vld     = 1'b0;
    pick_idx     = '0;
    sel_col      = '0;
    sel_blink    = 1'b0;

    tick      = (presc_q == PRESC_LAST);
    owner_req = bus.req[owner_q];

    // With no gap, re-arbitration happens straight out of SHOW, so search after the current owner.
    arb_base = (state_q == SHOW) ? owner_q : last_owner_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = OW'((32'(arb_base) + k) % NREQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (OW'(i) == pick_idx) begin
        sel_col   = bus.colour[3*i +: 3];
        sel_blink = bus.blink[i];
      end
    end

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (pick_vld) launch = 1'b1;
      end
      SHOW: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) ms_cnt_d = ms_cnt_q + 1'b1;
        if (tick && blink_en_q) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
        if ((tick && ms_cnt_q == SLOT_LAST) || !owner_req) begin
          last_owner_d = owner_q;
          if (GAP_MS != 0) to_gap = 1'b1;
          else if (pick_vld) launch = 1'b1;
          else to_idle = 1'b1;
        end
      end
      GAP: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) ms_cnt_d = ms_cnt_q + 1'b1;
        if (tick && ms_cnt_q == GAP_LAST) begin
          if (pick_vld) launch = 1'b1;
          else to_idle = 1'b1;
        end
      end
      default: to_idle = 1'b1;
    endcase

    if (launch) begin
      state_d    = SHOW;
      owner_d    = pick_idx;
      col_d      = sel_col;
      blink_en_d = sel_blink;
      phase_d    = 1'b1;
    end else if (to_gap) begin
      state_d = GAP;
    end else if (to_idle) begin
      state_d = IDLE;
    end
    if (launch || to_gap || to_idle) begin
      presc_d     = '0;
      ms_cnt_d    = '0;
      blink_cnt_d = '0;
    end

    // Outputs are derived from next-state values so the pins change on the same edge as the FSM.
    grant_d = '0;
    if (state_d == SHOW) grant_d[owner_d] = 1'b1;
    busy_d = (state_d != IDLE);
    lit    = (state_d == SHOW && (!blink_en_d || phase_d)) ? col_d : 3'b000;
    led_d  = lit ^ {3{LED_INV}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      ms_cnt_q     <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
      col_q        <= '0;
      blink_en_q   <= 1'b0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      led_q        <= {3{LED_INV}};
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      ms_cnt_q     <= ms_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      col_q        <= col_d;
      blink_en_q   <= blink_en_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      led_q        <= led_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign {redled, greenled, blueled} = led_q;

endmodule

// File: tb/tb_led_share_sched.sv
// Directed bench for led_share_sched: per-segment vector table plus hand-written corner sequences.
module tb_led_share_sched;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [2:0] OFF = 3'b111;
`else
  localparam logic [2:0] OFF = 3'b000;
`endif

  logic clk = 1'b0;
  logic rst;
  logic redled, greenled, blueled;

  led_share_sched_if #(.NREQ(4)) bus ();

  led_share_sched #(
    .NREQ(4), .TICK_DIV(4), .SLOT_MS(5), .BLINK_MS(2), .GAP_MS(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .redled   (redled),
    .greenled (greenled),
    .blueled  (blueled)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [11:0] colour;
    logic [3:0]  blink;
    int unsigned ncyc;
    logic [3:0]  g;
    logic        b;
    logic [2:0]  rgb;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(input logic r, input logic [3:0] rq, input logic [11:0] c,
                              input logic [3:0] bl, input int unsigned n,
                              input logic [3:0] g, input logic b, input logic [2:0] rgb);
    vec_t v;
    v.rst = r; v.req = rq; v.colour = c; v.blink = bl; v.ncyc = n;
    v.g = g; v.b = b; v.rgb = rgb;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] g, input logic b, input logic [2:0] rgb);
    logic [2:0] pins;
    pins = {redled, greenled, blueled};
    checks++;
    if (bus.grant !== g || bus.busy !== b || pins !== (rgb ^ OFF)) begin
      errors++;
      $display("FAIL %s: got grant=%b busy=%b pins=%b, expected grant=%b busy=%b pins=%b",
               name, bus.grant, bus.busy, pins, g, b, rgb ^ OFF);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [11:0] c, input logic [3:0] bl);
    rst = r; bus.req = rq; bus.colour = c; bus.blink = bl;
  endtask

  initial begin
    int n;
    // Reset then idle
    add(1, 4'b0000, 12'h000, 4'b0000,  2, 4'b0000, 0, 3'b000);
    add(0, 4'b0000, 12'h000, 4'b0000, 50, 4'b0000, 0, 3'b000);
    // Single steady green requester, regranted after the gap
    add(0, 4'b0001, 12'b000_000_000_010, 4'b0000, 20, 4'b0001, 1, 3'b010);
    add(0, 4'b0001, 12'b000_000_000_010, 4'b0000,  4, 4'b0000, 1, 3'b000);
    add(0, 4'b0001, 12'b000_000_000_010, 4'b0000, 20, 4'b0001, 1, 3'b010);
    add(1, 4'b0000, 12'h000, 4'b0000,  2, 4'b0000, 0, 3'b000);
    // Round-robin over 1011
    add(0, 4'b1011, 12'b001_111_010_100, 4'b0000, 20, 4'b0001, 1, 3'b100);
    add(0, 4'b1011, 12'b001_111_010_100, 4'b0000,  4, 4'b0000, 1, 3'b000);
    add(0, 4'b1011, 12'b001_111_010_100, 4'b0000, 20, 4'b0010, 1, 3'b010);
    add(0, 4'b1011, 12'b001_111_010_100, 4'b0000,  4, 4'b0000, 1, 3'b000);
    add(0, 4'b1011, 12'b001_111_010_100, 4'b0000, 20, 4'b1000, 1, 3'b001);
    add(0, 4'b1011, 12'b001_111_010_100, 4'b0000,  4, 4'b0000, 1, 3'b000);
    add(0, 4'b1011, 12'b001_111_010_100, 4'b0000, 20, 4'b0001, 1, 3'b100);
    add(1, 4'b0000, 12'h000, 4'b0000,  2, 4'b0000, 0, 3'b000);
    // Blink: on 8, off 8, on 4, gap, on again
    add(0, 4'b0100, 12'b000_111_000_000, 4'b0100, 8, 4'b0100, 1, 3'b111);
    add(0, 4'b0100, 12'b000_111_000_000, 4'b0100, 8, 4'b0100, 1, 3'b000);
    add(0, 4'b0100, 12'b000_111_000_000, 4'b0100, 4, 4'b0100, 1, 3'b111);
    add(0, 4'b0100, 12'b000_111_000_000, 4'b0100, 4, 4'b0000, 1, 3'b000);
    add(0, 4'b0100, 12'b000_111_000_000, 4'b0100, 8, 4'b0100, 1, 3'b111);
    add(1, 4'b0000, 12'h000, 4'b0000,  2, 4'b0000, 0, 3'b000);
    // Early release after 7 slice cycles, then release on the expiry edge
    add(0, 4'b0001, 12'b000_000_000_010, 4'b0000,  7, 4'b0001, 1, 3'b010);
    add(0, 4'b0000, 12'b000_000_000_010, 4'b0000,  4, 4'b0000, 1, 3'b000);
    add(0, 4'b0000, 12'b000_000_000_010, 4'b0000,  3, 4'b0000, 0, 3'b000);
    add(0, 4'b0001, 12'b000_000_000_010, 4'b0000, 20, 4'b0001, 1, 3'b010);
    add(0, 4'b0000, 12'b000_000_000_010, 4'b0000,  4, 4'b0000, 1, 3'b000);
    add(0, 4'b0000, 12'b000_000_000_010, 4'b0000,  3, 4'b0000, 0, 3'b000);
    add(1, 4'b0000, 12'h000, 4'b0000,  2, 4'b0000, 0, 3'b000);
    // Mid-slice colour change is ignored until the next grant
    add(0, 4'b0001, 12'b000_000_000_100, 4'b0000,  5, 4'b0001, 1, 3'b100);
    add(0, 4'b0001, 12'b000_000_000_001, 4'b0000, 15, 4'b0001, 1, 3'b100);
    add(0, 4'b0001, 12'b000_000_000_001, 4'b0000,  4, 4'b0000, 1, 3'b000);
    add(0, 4'b0001, 12'b000_000_000_001, 4'b0000,  3, 4'b0001, 1, 3'b001);
    // Reset mid-SHOW, then requester 0 wins first even though it owned last
    add(1, 4'b0001, 12'b000_000_000_001, 4'b0000,  1, 4'b0000, 0, 3'b000);
    add(0, 4'b1111, 12'b001_111_010_001, 4'b0000,  5, 4'b0001, 1, 3'b001);
    // Dark colour is still granted
    add(1, 4'b0000, 12'h000, 4'b0000,  2, 4'b0000, 0, 3'b000);
    add(0, 4'b1000, 12'b000_111_111_111, 4'b0000, 20, 4'b1000, 1, 3'b000);
    add(0, 4'b1000, 12'b000_111_111_111, 4'b0000,  4, 4'b0000, 1, 3'b000);
    add(0, 4'b1000, 12'b000_111_111_111, 4'b0000,  2, 4'b1000, 1, 3'b000);

    drive(1, 4'b0000, 12'h000, 4'b0000);
    foreach (vecs[v]) begin
      drive(vecs[v].rst, vecs[v].req, vecs[v].colour, vecs[v].blink);
      for (int unsigned c = 0; c < vecs[v].ncyc; c++) begin
        @(posedge clk); #1;
        check($sformatf("vec%0d_cyc%0d", v, c), vecs[v].g, vecs[v].b, vecs[v].rgb);
      end
    end

    // One-cycle grant latency from IDLE, then bounded wait for busy to fall after release
    drive(1, 4'b0000, 12'h000, 4'b0000);
    repeat (2) @(posedge clk);
    #1 drive(0, 4'b0010, 12'b000_000_110_000, 4'b0010);
    @(posedge clk); #1;
    check("latency_grant", 4'b0010, 1, 3'b110);
    drive(0, 4'b0000, 12'b000_000_110_000, 4'b0010);
    n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL release_to_idle: got %0d cycles until busy low, expected 5", n);
    end
    check("idle_after_release", 4'b0000, 0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_share_sched.md
# led_share_sched

Round-robin scheduler that shares the board's single RGB LED among up to NREQ status requesters. Each requester asks for the LED with a colour and a steady/blink mode. The block grants time slices measured in millisecond ticks derived from the on-chip system clock, inserts a dark gap between slices, and drives the three LED pins directly. It sits between the status sources in the top level and the redled/greenled/blueled pins.

## Interface
Parameters:
- NREQ, 4, number of requesters; legal range 2..8
- TICK_DIV, 20000, clk cycles per ms tick (20 MHz system clock)
- SLOT_MS, 500, slice length in ticks; must be ≥1
- BLINK_MS, 250, blink half-period in ticks; must be ≥1
- GAP_MS, 100, dark gap between slices in ticks; 0 means no gap

Ports:
- clk  input  1  system clock from the cell macro Sys_Clk0
- rst  input  1  reset, synchronous, active-high
- req  input  NREQ  per-requester request level
- colour  input  3*NREQ  per-requester colour; bits [3i+2]=red, [3i+1]=green, [3i]=blue
- blink  input  NREQ  per-requester mode; 1 = blink, 0 = steady
- grant  output  NREQ  one-hot current owner; all zero outside SHOW
- busy  output  1  high in SHOW and GAP
- redled  output  1  red LED pin
- greenled  output  1  green LED pin
- blueled  output  1  blue LED pin

## Operation
- FSM states: IDLE, SHOW, GAP.
- Prescaler counts 0..TICK_DIV-1 and pulses tick at TICK_DIV-1. It is cleared on every state entry, so slices are cycle-exact.
- IDLE: LEDs off, grant=0, busy=0. If any req bit is high, pick the first set bit strictly after last_owner, wrapping modulo NREQ. Latch that requester's colour and blink bits, set grant, and enter SHOW.
- SHOW:
  - Latched colour drives the LEDs. Changes to colour or blink mid-slice are ignored.
  - Blink mode: phase starts on and toggles every BLINK_MS ticks. LEDs show colour when phase is on, all off otherwise.
  - Leave SHOW when SLOT_MS ticks have elapsed or the owner's req is low, whichever comes first. If both happen on the same cycle, treat it as one exit.
  - On exit, last_owner := owner and go to GAP. If GAP_MS=0, go directly to the arbitration described for IDLE.
- GAP: LEDs off, grant=0, busy=1. After GAP_MS ticks, arbitrate as in IDLE. If no req is high, go to IDLE.
- A sole persistent requester is re-granted after every gap.
- colour=000 with req high is legal: the slice is granted and the LED stays dark.
- Reset: state=IDLE, all LEDs at the off level, grant=0, busy=0, counters=0, last_owner=NREQ-1 (so requester 0 has first priority).
- Reset asserted mid-SHOW or mid-GAP takes effect at that edge.

## Timing
- req rising in IDLE at edge N gives grant and LED on at edge N+1 (one-cycle latency).
- SHOW lasts exactly SLOT_MS*TICK_DIV cycles when not cut short.
- Owner req low sampled at edge M: grant drops and LEDs go off at M+1.
- GAP lasts exactly GAP_MS*TICK_DIV cycles. The next grant appears on the cycle after the gap ends.
- Blink edges fall at multiples of BLINK_MS*TICK_DIV cycles from slice start.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- LED_ACTIVE_LOW_EN defined: pins are active-low, so on = 0 and off/reset level = 1. This matches the board's common-anode LED.
- Not defined: pins are active-high, so on = 1 and off/reset level = 0.
- grant and busy are unaffected by the macro.

## Test plan
Bench parameters for all scenarios: NREQ=4, TICK_DIV=4, SLOT_MS=5, BLINK_MS=2, GAP_MS=1.
- Reset then idle: rst high 2 cycles, req=0 → grant=0, busy=0, LEDs at off level for 50 cycles.
- Single steady requester: req=0001, colour0=010, blink0=0 → grant=0001 one cycle later; greenled on for exactly 20 cycles, 4 dark cycles, then regranted.
- Round-robin: req=1011, all held → grant sequence 0001, 0010, 1000, 0001, with 20-cycle slices and 4-cycle gaps.
- Blink: req=0100, colour2=111, blink2=1 → all LEDs on 8 cycles, off 8, on 4, then gap.
- Early release and simultaneous events: owner req drops at cycle 7 of the slice → grant=0 the next cycle. A drop on the same cycle as expiry gives a single GAP entry.
- Mid-slice reset and colour change:
  - colour0 changes from 100 to 001 mid-slice → red stays on until the slice ends.
  - rst pulse mid-SHOW → all outputs off next edge; after release, requester 0 is granted first.
